pipelined_barrel_shifter: RTL and testbench

//   Parametrised, fully pipelined barrel shifter for the datapath library.

---
 rtl/pipelined_barrel_shifter_if.sv | 31 +++
 rtl/pipelined_barrel_shifter.sv | 99 +++++++++
 tb/tb_pipelined_barrel_shifter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Request/result stream bundle for the pipelined barrel shifter.
// A beat transfers on the rising edge where valid && ready are both high; valid and its payload hold until then.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: SLL/SRL/SRA/ROR, one power-of-two shift step per register.
// Stage 0 captures the request; stage k+1 applies the 2^k step; the last stage is the output register.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input logic                                clk,
  input logic                                rst_n,
  pipelined_barrel_shifter_if.slave          bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    op_e              op;
    logic [TAG_W-1:0] tag;
    logic             sign;
    logic             zero;
  } item_t;

  item_t stg [0:SHW];
  item_t nxt [0:SHW];
  logic  stall;

  // The whole pipeline freezes only when a finished result is refused.
  assign stall        = stg[SHW].valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input op_e              op,
    input logic             sign,
    input int               amt
  );
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] res;
    fill = ~({WIDTH{1'b1}} >> amt);
    res  = d;
    case (op)
      OP_SLL:  res = d << amt;
      OP_SRL:  res = d >> amt;
      OP_SRA:  res = (d >> amt) | (sign ? fill : '0);
      default: res = (d >> amt) | (d << (WIDTH - amt));
    endcase
    return res;
  endfunction

  always_comb begin
    for (int k = 0; k <= SHW; k++) begin
      nxt[k] = '0;
    end
    nxt[0].valid = bus.in_valid;
    nxt[0].data  = bus.in_data;
    nxt[0].shamt = bus.in_shamt;
    nxt[0].op    = op_e'(bus.in_op);
    nxt[0].tag   = bus.in_tag;
    nxt[0].sign  = bus.in_data[WIDTH-1];
    nxt[0].zero  = (bus.in_data == '0);
    // The sign bit is carried separately so SRA fills from the original operand.
    for (int k = 0; k < SHW; k++) begin
      nxt[k+1] = stg[k];
      if (stg[k].shamt[k]) begin
        nxt[k+1].data = shift_step(stg[k].data, stg[k].op, stg[k].sign, 1 << k);
      end
      nxt[k+1].zero = (nxt[k+1].data == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= SHW; k++) begin
        stg[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k <= SHW; k++) begin
        stg[k] <= nxt[k];
      end
    end
  end

  assign bus.out_valid = stg[SHW].valid;
  assign bus.out_data  = stg[SHW].data;
  assign bus.out_tag   = stg[SHW].tag;
  assign bus.out_zero  = stg[SHW].zero;

  stall_holds_output: assert property (
    @(posedge clk) disable iff (!rst_n)
    stall |=> (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_tag) && $stable(bus.out_zero))
  );
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed cases, backpressure, random stream and mid-flight reset.
module tb_pipelined_barrel_shifter;
  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int SHW   = 3;
  localparam int LAT   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int consumed = 0;
  int rdy_mode = 0;

  logic [TAG_W+WIDTH-1:0] exp_q[$];
  int                     acc_q[$];
  bit                     lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: shift semantics as plain integer arithmetic on the unsigned operand.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int s, input int op);
    int v;
    int dv;
    dv = int'(d);
    case (op)
      0: v = (dv * (2 ** s)) % (2 ** WIDTH);
      1: v = dv / (2 ** s);
      2: begin
        v = dv / (2 ** s);
        if (dv >= 2 ** (WIDTH - 1)) v = v + (2 ** WIDTH) - (2 ** (WIDTH - s));
      end
      default: v = (dv / (2 ** s)) + (dv % (2 ** s)) * (2 ** (WIDTH - s));
    endcase
    return v[WIDTH-1:0];
  endfunction

  // out_ready is updated 2 time units after each rising edge, per the selected mode.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s, input logic [1:0] op,
                      input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp_d, input bit lat);
    int waited;
    bit ok;
    waited       = 0;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_op    = op;
    bus.in_tag   = tag;
    while (!ok && waited < 500) begin
      @(negedge clk);
      if (bus.in_ready && rst_n) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%0d in_ready=%0b required=1", tag, bus.in_ready);
    end else begin
      exp_q.push_back({tag, exp_d});
      acc_q.push_back(cyc + 1);
      lat_q.push_back(lat);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] tag);
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   s;
    logic [1:0]       op;
    d  = WIDTH'($urandom_range(0, 255));
    s  = SHW'($urandom_range(0, 7));
    op = 2'($urandom_range(0, 3));
    send(d, s, op, tag, ref_shift(d, int'(s), int'(op)), 1'b0);
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout pending=%0d required=0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations on every output transfer and checks stall stability.
  initial begin
    logic [WIDTH-1:0]       p_data;
    logic [TAG_W-1:0]       p_tag;
    logic                   p_zero;
    bit                     p_stall;
    logic [TAG_W+WIDTH-1:0] e;
    int                     a;
    bit                     l;
    p_stall = 1'b0;
    p_data  = '0;
    p_tag   = '0;
    p_zero  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_stall = 1'b0;
        continue;
      end
      if (p_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", 32'(bus.out_data), 32'(p_data));
        chk("stall_tag", 32'(bus.out_tag), 32'(p_tag));
        chk("stall_zero", 32'(bus.out_zero), 32'(p_zero));
      end
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        consumed++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output tag=%0d data=0x%0h required=none", bus.out_tag, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          l = lat_q.pop_front();
          chk("out_tag", 32'(bus.out_tag), 32'(e[TAG_W+WIDTH-1:WIDTH]));
          chk("out_data", 32'(bus.out_data), 32'(e[WIDTH-1:0]));
          chk("out_zero", 32'(bus.out_zero), 32'(e[WIDTH-1:0] == '0));
          if (l) chk("latency", 32'(cyc - a), 32'(LAT));
        end
      end
      p_stall = bus.out_valid && !bus.out_ready;
      p_data  = bus.out_data;
      p_tag   = bus.out_tag;
      p_zero  = bus.out_zero;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    checks++;
    errors++;
    $display("FAIL watchdog cycles=%0d required<60000", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  logic [WIDTH-1:0] t1_exp [4];
  logic [WIDTH-1:0] t2_din [2];
  int               c0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shamt = '0;
    bus.in_op    = '0;
    bus.in_tag   = '0;
    t1_exp[0] = 8'h90;
    t1_exp[1] = 8'h1A;
    t1_exp[2] = 8'hFA;
    t1_exp[3] = 8'h5A;
    t2_din[0] = 8'hD2;
    t2_din[1] = 8'h52;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: 0xD2 shamt=3, each op back to back, tags 1..4
    for (int i = 0; i < 4; i++) send(8'hD2, 3'd3, 2'(i), 4'(i + 1), t1_exp[i], 1'b1);
    drain("t1");

    // 2: shamt=0 identity, SRA sign fill, zero flag
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++) send(t2_din[j], 3'd0, 2'(i), 4'(j * 4 + i), t2_din[j], 1'b1);
    send(8'h80, 3'd7, 2'd2, 4'd8, 8'hFF, 1'b1);
    send(8'h01, 3'd1, 2'd1, 4'd9, 8'h00, 1'b1);
    drain("t2");

    // 3: backpressure with tags 0..9
    c0 = consumed;
    rdy_mode = 1;
    fork
      for (int i = 0; i < 10; i++) send_rand(4'(i));
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_head_tag", 32'(bus.out_tag), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain("t3");
    chk("bp_count", 32'(consumed - c0), 32'd10);

    // 4: random stream with random gaps and random backpressure
    c0 = consumed;
    rdy_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand(4'(i));
    end
    rdy_mode = 0;
    drain("t4");
    chk("rand_count", 32'(consumed - c0), 32'd2000);

    // 5: reset with three items in flight
    for (int i = 0; i < 3; i++) send_rand(4'(i + 5));
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = consumed;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_items", 32'(consumed - c0), 32'd0);
    send(8'hD2, 3'd3, 2'd3, 4'd15, 8'h5A, 1'b1);
    drain("t5");
    chk("post_rst_count", 32'(consumed - c0), 32'd1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
